// File: rtl/ballot_box_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ballot_box_scheduler
// Brief    : Election phase sequencer with round-robin sharing of one datapath
//            port among four ballot boxes. BOX0_PRIORITY_EN gives box 0 fixed
//            absolute priority over boxes 1-3.
// Revision : 1.0 - initial release
// ============================================================================
module ballot_box_scheduler #(
    parameter int REG_CYCLES  = 100,
    parameter int VOTE_CYCLES = 100,
    parameter int ID_W        = 6
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              start,
    input  logic [3:0]        req,
    input  logic [4*ID_W-1:0] box_user_id,
    input  logic [7:0]        box_cand,
    output logic [3:0]        gnt,
    output logic              dp_valid,
    output logic [1:0]        dp_mode,
    output logic [ID_W-1:0]   dp_user_id,
    output logic [1:0]        dp_cand,
    output logic              dp_clear,
    output logic [2:0]        phase,
    output logic [7:0]        reject_cnt
);

    localparam int c_MAX_LEN = (REG_CYCLES > VOTE_CYCLES) ? REG_CYCLES : VOTE_CYCLES;
    localparam int c_CNT_W   = (c_MAX_LEN > 1) ? $clog2(c_MAX_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_REG_LAST  = c_CNT_W'(REG_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_VOTE_LAST = c_CNT_W'(VOTE_CYCLES - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_REG   = 3'd1;
    localparam logic [2:0] c_ST_VOTE  = 3'd2;
    localparam logic [2:0] c_ST_TALLY = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

`ifdef BOX0_PRIORITY_EN
    localparam logic [1:0] c_PTR_RST = 2'd1;
`else
    localparam logic [1:0] c_PTR_RST = 2'd0;
`endif

    logic [2:0]         r_phase;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_ptr;
    logic [3:0]         r_gnt;
    logic               r_dp_valid;
    logic [1:0]         r_dp_mode;
    logic [ID_W-1:0]    r_dp_user_id;
    logic [1:0]         r_dp_cand;
    logic               r_dp_clear;
    logic [7:0]         r_reject_cnt;

    logic [2:0]         w_next_phase;
    logic [c_CNT_W-1:0] w_next_cnt;
    logic [1:0]         w_next_mode;
    logic               w_last;
    logic               w_idle_done;
    logic               w_arb_phase;
    logic               w_arb_en;
    logic [3:0]         w_elig;
    logic               w_found;
    logic [1:0]         w_win;
    logic [1:0]         w_next_ptr;
    logic [3:0]         w_grant_oh;
    logic [3:0]         w_rej_bits;
    logic [2:0]         w_rej_num;
    logic [8:0]         w_rej_sum;
`ifdef BOX0_PRIORITY_EN
    logic [2:0]         w_idx3;
`else
    logic [1:0]         w_idx;
`endif

    assign w_idle_done = (r_phase == c_ST_IDLE) || (r_phase == c_ST_DONE);
    assign w_last      = ((r_phase == c_ST_REG)  && (r_cnt == c_REG_LAST)) ||
                         ((r_phase == c_ST_VOTE) && (r_cnt == c_VOTE_LAST));

    always_comb begin
        w_next_phase = r_phase;
        w_next_cnt   = r_cnt;
        case (r_phase)
            c_ST_IDLE, c_ST_DONE: begin
                if (start) begin
                    w_next_phase = c_ST_REG;
                    w_next_cnt   = '0;
                end
            end
            c_ST_REG: begin
                if (w_last) begin
                    w_next_phase = c_ST_VOTE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            c_ST_VOTE: begin
                if (w_last) begin
                    w_next_phase = c_ST_TALLY;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            c_ST_TALLY: w_next_phase = c_ST_DONE;
            default:    w_next_phase = c_ST_IDLE;
        endcase
    end

    // Outputs are registered, so the mode shown tracks the phase being entered.
    always_comb begin
        case (w_next_phase)
            c_ST_VOTE:  w_next_mode = 2'd1;
            c_ST_TALLY: w_next_mode = 2'd2;
            default:    w_next_mode = 2'd0;
        endcase
    end

    // The final VOTE slot belongs to the tally transaction.
    assign w_arb_phase = (r_phase == c_ST_REG) || (r_phase == c_ST_VOTE);
    assign w_arb_en    = w_arb_phase && !((r_phase == c_ST_VOTE) && w_last);
    assign w_elig      = w_arb_en ? (req & ~r_gnt) : 4'b0000;

    always_comb begin
        w_found    = 1'b0;
        w_win      = 2'd0;
        w_next_ptr = r_ptr;
`ifdef BOX0_PRIORITY_EN
        w_idx3 = 3'd0;
        if (w_elig[0]) begin
            w_found = 1'b1;
            w_win   = 2'd0;
        end else begin
            // Descending scan so the candidate nearest the pointer wins last.
            for (int i = 2; i >= 0; i--) begin
                w_idx3 = {1'b0, r_ptr} + 3'(i);
                if (w_idx3 > 3'd3) w_idx3 = w_idx3 - 3'd3;
                if (w_elig[w_idx3[1:0]]) begin
                    w_found = 1'b1;
                    w_win   = w_idx3[1:0];
                end
            end
        end
        if (w_found && (w_win != 2'd0))
            w_next_ptr = (w_win == 2'd3) ? 2'd1 : (w_win + 2'd1);
`else
        w_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            w_idx = r_ptr + 2'(i);
            if (w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        if (w_found)
            w_next_ptr = w_win + 2'd1;
`endif
    end

    assign w_grant_oh = w_found ? (4'b0001 << w_win) : 4'b0000;

    // Boxes just granted are still dropping req and are not counted as rejects.
    assign w_rej_bits = req & ~w_grant_oh & (w_arb_phase ? ~r_gnt : 4'b1111);
    assign w_rej_num  = {2'b00, w_rej_bits[0]} + {2'b00, w_rej_bits[1]} +
                        {2'b00, w_rej_bits[2]} + {2'b00, w_rej_bits[3]};
    assign w_rej_sum  = {1'b0, r_reject_cnt} + {6'b000000, w_rej_num};

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_phase      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_ptr        <= c_PTR_RST;
            r_gnt        <= 4'b0000;
            r_dp_valid   <= 1'b0;
            r_dp_mode    <= 2'd0;
            r_dp_user_id <= '0;
            r_dp_cand    <= 2'd0;
            r_dp_clear   <= 1'b0;
            r_reject_cnt <= 8'd0;
        end else begin
            r_phase      <= w_next_phase;
            r_cnt        <= w_next_cnt;
            r_ptr        <= w_next_ptr;
            r_gnt        <= w_grant_oh;
            r_dp_valid   <= w_found || ((r_phase == c_ST_VOTE) && w_last);
            r_dp_mode    <= w_next_mode;
            r_dp_user_id <= w_found ? box_user_id[w_win*ID_W +: ID_W] : '0;
            r_dp_cand    <= w_found ? box_cand[w_win*2 +: 2] : 2'd0;
            r_dp_clear   <= w_idle_done && start;
            if (w_idle_done && start)
                r_reject_cnt <= 8'd0;
            else if (w_rej_sum > 9'd255)
                r_reject_cnt <= 8'hFF;
            else
                r_reject_cnt <= w_rej_sum[7:0];
        end
    end

    assign phase      = r_phase;
    assign gnt        = r_gnt;
    assign dp_valid   = r_dp_valid;
    assign dp_mode    = r_dp_mode;
    assign dp_user_id = r_dp_user_id;
    assign dp_cand    = r_dp_cand;
    assign dp_clear   = r_dp_clear;
    assign reject_cnt = r_reject_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ballot_box_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ballot_box_scheduler
// Brief    : Directed bench: phase timing, arbitration, masking, rejects, reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ballot_box_scheduler;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        start_a, start_b;
    logic [3:0]  req;
    logic [23:0] box_user_id;
    logic [7:0]  box_cand;

    logic [3:0] a_gnt, b_gnt;
    logic       a_dp_valid, b_dp_valid;
    logic [1:0] a_dp_mode, b_dp_mode;
    logic [5:0] a_dp_user_id, b_dp_user_id;
    logic [1:0] a_dp_cand, b_dp_cand;
    logic       a_dp_clear, b_dp_clear;
    logic [2:0] a_phase, b_phase;
    logic [7:0] a_reject_cnt, b_reject_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    int exp_ph   [1:9] = '{1, 1, 1, 1, 2, 2, 2, 3, 4};
    int exp_mode [1:9] = '{0, 0, 0, 0, 1, 1, 1, 2, 0};
    int exp_val  [1:9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
`ifdef BOX0_PRIORITY_EN
    int exp_gnt  [0:7] = '{1, 2, 1, 4, 1, 8, 1, 2};
`else
    int exp_gnt  [0:7] = '{1, 2, 4, 8, 1, 2, 4, 8};
`endif

    always #5 CLK = ~CLK;

    ballot_box_scheduler #(.REG_CYCLES(4), .VOTE_CYCLES(3), .ID_W(6)) dut_a (
        .CLK(CLK), .RSTN(RSTN), .start(start_a), .req(req),
        .box_user_id(box_user_id), .box_cand(box_cand),
        .gnt(a_gnt), .dp_valid(a_dp_valid), .dp_mode(a_dp_mode),
        .dp_user_id(a_dp_user_id), .dp_cand(a_dp_cand), .dp_clear(a_dp_clear),
        .phase(a_phase), .reject_cnt(a_reject_cnt)
    );

    ballot_box_scheduler #(.REG_CYCLES(8), .VOTE_CYCLES(40), .ID_W(6)) dut_b (
        .CLK(CLK), .RSTN(RSTN), .start(start_b), .req(req),
        .box_user_id(box_user_id), .box_cand(box_cand),
        .gnt(b_gnt), .dp_valid(b_dp_valid), .dp_mode(b_dp_mode),
        .dp_user_id(b_dp_user_id), .dp_cand(b_dp_cand), .dp_clear(b_dp_clear),
        .phase(b_phase), .reject_cnt(b_reject_cnt)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        RSTN = 1'b0; start_a = 1'b0; start_b = 1'b0;
        req = 4'b0000; box_user_id = '0; box_cand = '0;
        tick;
        chk("rst_phase", a_phase, 0);
        chk("rst_gnt", a_gnt, 0);
        chk("rst_valid", a_dp_valid, 0);
        chk("rst_clear", a_dp_clear, 0);
        chk("rst_mode", a_dp_mode, 0);
        chk("rst_rej", a_reject_cnt, 0);
        chk("rst_phase_b", b_phase, 0);
        RSTN = 1'b1;
        tick; tick;

        // Phase sequence on the short instance
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) tick;
            chk($sformatf("seq_phase_c%0d", c), a_phase, exp_ph[c]);
            chk($sformatf("seq_mode_c%0d", c), a_dp_mode, exp_mode[c]);
            chk($sformatf("seq_valid_c%0d", c), a_dp_valid, exp_val[c]);
            chk($sformatf("seq_clear_c%0d", c), a_dp_clear, (c == 1) ? 1 : 0);
        end

        // Rejects while DONE, then saturation
        req = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("done_gnt", a_gnt, 0);
            chk("done_valid", a_dp_valid, 0);
        end
        chk("done_rej6", a_reject_cnt, 6);
        repeat (124) tick;
        chk("done_rej254", a_reject_cnt, 254);
        tick;
        chk("done_rej255", a_reject_cnt, 255);
        repeat (173) tick;
        chk("done_rej_sat", a_reject_cnt, 255);
        req = 4'b0000;

        // Round-robin with every box requesting in REGISTER
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        chk("b_clear", b_dp_clear, 1);
        chk("b_clear_valid", b_dp_valid, 0);
        chk("b_phase_reg", b_phase, 1);
        chk("b_rej_cleared", b_reject_cnt, 0);
        box_user_id = {6'd13, 6'd12, 6'd11, 6'd10};
        box_cand    = 8'b11_10_01_00;
        req = 4'b1111;
        tick;
        chk("rr_gnt0", b_gnt, 4'b0001);
        chk("rr_id0", b_dp_user_id, 10);
        chk("rr_cand0", b_dp_cand, 0);
        chk("rr_valid0", b_dp_valid, 1);
        chk("rr_mode0", b_dp_mode, 0);
        tick;
        chk("rr_gnt1", b_gnt, 4'b0010);
        chk("rr_id1", b_dp_user_id, 11);
        chk("rr_cand1", b_dp_cand, 1);
        req = 4'b1110;
        tick;
        chk("rr_gnt2", b_gnt, 4'b0100);
        chk("rr_id2", b_dp_user_id, 12);
        req = 4'b1100;
        tick;
        chk("rr_gnt3", b_gnt, 4'b1000);
        chk("rr_id3", b_dp_user_id, 13);
        chk("rr_cand3", b_dp_cand, 3);
        req = 4'b1000;
        tick;
        chk("rr_no_repeat", b_gnt, 0);
        chk("rr_no_valid", b_dp_valid, 0);
        req = 4'b0000;
        chk("rr_rej", b_reject_cnt, 6);

        // Single requester in VOTE
        w = 0;
        while (b_phase !== 3'd2 && w < 20) begin
            tick;
            w++;
        end
        chk("wait_vote", b_phase, 2);
        chk("vote_mode", b_dp_mode, 1);
        box_user_id[17:12] = 6'd37;
        box_cand[5:4]      = 2'b11;
        req = 4'b0100;
        tick;
        chk("v_gnt", b_gnt, 4'b0100);
        chk("v_mode", b_dp_mode, 1);
        chk("v_id", b_dp_user_id, 37);
        chk("v_cand", b_dp_cand, 3);
        chk("v_valid", b_dp_valid, 1);
        tick;
        chk("v_masked_gnt", b_gnt, 0);
        chk("v_masked_valid", b_dp_valid, 0);
        req = 4'b0000;
        chk("v_masked_rej", b_reject_cnt, 6);

        // Asynchronous reset at VOTE counter 37
        repeat (35) tick;
        chk("pre_rst_phase", b_phase, 2);
        RSTN = 1'b0;
        #1;
        chk("arst_phase", b_phase, 0);
        chk("arst_gnt", b_gnt, 0);
        chk("arst_valid", b_dp_valid, 0);
        chk("arst_rej", b_reject_cnt, 0);
        tick;
        RSTN = 1'b1;
        tick;
        chk("post_rst_valid", b_dp_valid, 0);
        chk("post_rst_phase", b_phase, 0);

        // Continuous requests from all boxes; last REGISTER sample lands in VOTE
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        chk("r2_clear", b_dp_clear, 1);
        chk("r2_phase", b_phase, 1);
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick;
            chk($sformatf("arb_gnt_%0d", i), b_gnt, exp_gnt[i]);
            chk($sformatf("arb_mode_%0d", i), b_dp_mode, (i == 7) ? 1 : 0);
        end
        chk("boundary_valid", b_dp_valid, 1);
        req = 4'b0000;

        // Request in the last VOTE cycle yields to TALLY
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        repeat (6) tick;
        chk("lv_phase", a_phase, 2);
        req = 4'b0001;
        tick;
        chk("tally_phase", a_phase, 3);
        chk("tally_gnt", a_gnt, 0);
        chk("tally_valid", a_dp_valid, 1);
        chk("tally_mode", a_dp_mode, 2);
        chk("tally_id", a_dp_user_id, 0);
        chk("tally_cand", a_dp_cand, 0);
        req = 4'b0000;
        tick;
        chk("after_tally_phase", a_phase, 4);
        chk("after_tally_valid", a_dp_valid, 0);
        chk("lv_rej", a_reject_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ballot_box_scheduler.md
Name: ballot_box_scheduler

Overview:
- Front-end controller for the avatar-election registration/voting datapath.
- Sequences the election phases IDLE -> REGISTER -> VOTE -> TALLY -> DONE with programmable phase lengths.
- Shares the single datapath port between four ballot boxes using round-robin arbitration.
- Drives mode, userID and candidate to the datapath, one transaction per cycle at most.

Parameters:
- REG_CYCLES, 100, length of the REGISTER phase in clock cycles (>=1).
- VOTE_CYCLES, 100, length of the VOTE phase in clock cycles (>=1).
- ID_W, 6, width of userID.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RSTN  input  1  asynchronous active-low reset.
- start  input  1  begins a new election from IDLE or DONE.
- req  input  4  per-box request; bit k = ballot box k.
- box_user_id  input  4*ID_W  box k's userID in bits [k*ID_W +: ID_W].
- box_cand  input  8  box k's candidate in bits [2k +: 2]; 00 Air, 01 Fire, 10 Earth, 11 Water.
- gnt  output  4  one-hot, registered, single-cycle grant pulse.
- dp_valid  output  1  datapath transaction valid this cycle.
- dp_mode  output  2  0 = register, 1 = vote, 2 = tally.
- dp_user_id  output  ID_W  userID of the granted box.
- dp_cand  output  2  candidate of the granted box.
- dp_clear  output  1  one-cycle pulse that clears datapath tallies at election start.
- phase  output  3  0 IDLE, 1 REGISTER, 2 VOTE, 3 TALLY, 4 DONE.
- reject_cnt  output  8  count of box-cycles with req high but not serviceable; saturates at 255.

Behaviour:
- Reset (RSTN=0, asynchronous):
  - phase=IDLE, gnt=0, dp_valid=0, dp_mode=0, dp_user_id=0, dp_cand=0, dp_clear=0, reject_cnt=0.
  - Round-robin pointer = box 0; phase cycle counter = 0.
  - Reset mid-phase aborts the election; no further dp_valid until the next start.
- IDLE/DONE:
  - start=1 -> next cycle phase=REGISTER, dp_clear=1 for exactly that cycle, counter=0, reject_cnt=0.
  - start is ignored in all other phases.
- REGISTER:
  - Lasts exactly REG_CYCLES cycles (counter 0..REG_CYCLES-1), then VOTE with counter reset.
  - dp_mode=0 throughout the phase.
- VOTE:
  - Lasts exactly VOTE_CYCLES cycles, then TALLY.
  - dp_mode=1 throughout the phase.
- TALLY:
  - Exactly 1 cycle with dp_valid=1, dp_mode=2, dp_user_id=0, dp_cand=0; gnt=0.
  - Next cycle enters DONE.
- Arbitration (REGISTER and VOTE only):
  - Sampled at cycle N; registered outputs at N+1: gnt[k]=1, dp_valid=1, dp_user_id/dp_cand = box k's values sampled at N.
  - Winner k is the first requesting box searching from the pointer upward, modulo 4.
  - After a grant to box k, the pointer moves to (k+1) mod 4.
  - A box whose gnt is high at N is masked from arbitration at N (no double grant while its req is still dropping).
  - Requester holds req/user_id/cand stable until it sees gnt, then deasserts req the cycle after gnt.
  - No requests -> dp_valid=0, gnt=0, pointer unchanged.
- Phase boundary:
  - A request sampled in the last cycle of a phase is granted in the first cycle of the next phase, with dp_mode reflecting the new phase.
  - Requests sampled in the last VOTE cycle are not granted; TALLY takes the slot.
- reject_cnt:
  - Increments by the number of set req bits in any IDLE/TALLY/DONE cycle.
  - Also increments by the number of set req bits not granted and not masked in REGISTER/VOTE.
  - Saturates at 255.
- dp_clear and dp_valid are never high in the same cycle.

Optional Feature:
- Macro: BOX0_PRIORITY_EN.
- Defined: box 0 has fixed absolute priority; a requesting, unmasked box 0 always wins. Boxes 1-3 round-robin among themselves, and the pointer only tracks boxes 1-3.
- Undefined: pure 4-way round-robin as described in Behaviour.

Test Plan:
- Reset mid-VOTE at counter 37 -> phase=IDLE immediately; gnt, dp_valid, reject_cnt = 0; start gives dp_clear pulse, then REGISTER.
- REG_CYCLES=4, VOTE_CYCLES=3, start at cycle 0 -> dp_clear at 1, REGISTER cycles 1-4, VOTE 5-7, TALLY 8 (dp_mode=2, dp_valid=1), DONE from 9.
- All four req held continuously in REGISTER, box k deasserting after its gnt -> grants 0,1,2,3 in consecutive cycles with matching dp_user_id; no repeat grant.
- Box 2 alone holds req (user_id=6'd37, cand=2'b11) in VOTE -> gnt=4'b0100, dp_mode=1, dp_user_id=37, dp_cand=3 one cycle later; masked in the following cycle.
- req=4'b1010 during DONE for 3 cycles -> no gnt, reject_cnt=6; 300 such cycles -> reject_cnt=255.
- With BOX0_PRIORITY_EN defined, req=4'b1111 with box 0 re-requesting every other cycle -> box 0 granted in each cycle it is unmasked; boxes 1-3 rotate in the gaps.
